lcd_scanout: RTL and testbench



---
 rtl/lcd_scanout.sv | 160 ++++++++++++++++
 tb/tb_lcd_scanout.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scanout.sv
// Parallel RGB LCD scanout: pixel clock, hsync/vsync/DE timing, RGB332->RGB888 from a 1-clk-latency framebuffer.
// Outputs are registered on each pixel tick; no backpressure, the panel timing is free-running.
module lcd_scanout #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter int PIX_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] rad,
    input  logic [7:0]  rdata,
    output logic        lcd_pclk,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic [7:0]  lcd_r,
    output logic [7:0]  lcd_g,
    output logic [7:0]  lcd_b,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(PIX_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(PIX_DIV / 2);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0]   RAD_LAST = 32'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q, div_d;
    logic [HW-1:0]   hc_q, hc_d;
    logic [VW-1:0]   vc_q, vc_d;
    logic [31:0]     rad_q, rad_d;
    logic            pclk_q, pclk_d;
    logic            hsync_q, vsync_q, de_q;
    logic [7:0]      r_q, g_q, b_q;
    logic [7:0]      r_d, g_d, b_d;
    logic            fs_q, busy_q;
    logic            tick, active, h_end, at_last;
    logic            hsync_d, vsync_d;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + 1'b1;
        pclk_d  = (div_d >= DIV_HALF);

        active  = (hc_q < H_ACT) && (vc_q < V_ACT);
        h_end   = (hc_q == H_LAST);
        at_last = h_end && (vc_q == V_LAST);

        hc_d = h_end ? '0 : hc_q + 1'b1;
        vc_d = vc_q;
        if (h_end) begin
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end

        // rad always points at the next active pixel, so it only moves past active slots
        rad_d = rad_q;
        if (active) begin
            rad_d = (rad_q == RAD_LAST) ? '0 : rad_q + 32'd1;
        end

        hsync_d = !((hc_q >= HS_BEG) && (hc_q < HS_END));
        vsync_d = !((vc_q >= VS_BEG) && (vc_q < VS_END));

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active) begin
            r_d = {rdata[7:5], rdata[7:5], rdata[7:6]};
            g_d = {rdata[4:2], rdata[4:2], rdata[4:3]};
            b_d = {rdata[1:0], rdata[1:0], rdata[1:0], rdata[1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            rad_q   <= '0;
            pclk_q  <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            pclk_q <= pclk_d;
            fs_q   <= 1'b0;
            if (tick) begin
                if ((state_q != IDLE) && !en && at_last) begin
                    // last slot of the frame is blanking, so dropping to idle here is glitch-free
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    hc_q    <= '0;
                    vc_q    <= '0;
                    rad_q   <= '0;
                    hsync_q <= 1'b1;
                    vsync_q <= 1'b1;
                    de_q    <= 1'b0;
                    r_q     <= '0;
                    g_q     <= '0;
                    b_q     <= '0;
                end else if ((state_q != IDLE) || en) begin
                    state_q <= en ? RUN : STOP;
                    busy_q  <= 1'b1;
                    hc_q    <= hc_d;
                    vc_q    <= vc_d;
                    rad_q   <= rad_d;
                    hsync_q <= hsync_d;
                    vsync_q <= vsync_d;
                    de_q    <= active;
                    r_q     <= r_d;
                    g_q     <= g_d;
                    b_q     <= b_d;
                    fs_q    <= (hc_q == '0) && (vc_q == '0);
                end
            end
        end
    end

    assign rad         = rad_q;
    assign lcd_pclk    = pclk_q;
    assign lcd_hsync   = hsync_q;
    assign lcd_vsync   = vsync_q;
    assign lcd_de      = de_q;
    assign lcd_r       = r_q;
    assign lcd_g       = g_q;
    assign lcd_b       = b_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: two small-geometry instances (PIX_DIV 2 and 4) against a frame-index reference model.
module tb_lcd_scanout;

    localparam int HA = 4, HFP = 1, HS = 1, HBP = 1;
    localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int TOT = HT * VT;
    localparam int NPIX = HA * VA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rad_a, rad_b;
    logic [7:0]  rdata_a, rdata_b;
    logic        pclk_a, hs_a, vs_a, de_a, fs_a, busy_a;
    logic        pclk_b, hs_b, vs_b, de_b, fs_b, busy_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    logic [7:0] mem [64];

    lcd_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                  .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIX_DIV(2)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .rad(rad_a), .rdata(rdata_a),
        .lcd_pclk(pclk_a), .lcd_hsync(hs_a), .lcd_vsync(vs_a), .lcd_de(de_a),
        .lcd_r(r_a), .lcd_g(g_a), .lcd_b(b_a), .frame_start(fs_a), .busy(busy_a));

    lcd_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                  .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIX_DIV(4)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .rad(rad_b), .rdata(rdata_b),
        .lcd_pclk(pclk_b), .lcd_hsync(hs_b), .lcd_vsync(vs_b), .lcd_de(de_b),
        .lcd_r(r_b), .lcd_g(g_b), .lcd_b(b_b), .frame_start(fs_b), .busy(busy_b));

    // synchronous-read framebuffer, one clk of latency
    always @(posedge clk) begin
        rdata_a <= mem[rad_a[5:0]];
        rdata_b <= mem[rad_b[5:0]];
    end

    // reference model: a frame position index per instance, plus a clk count for the divider phase
    int         m_t [2];
    int         m_n [2];
    bit         m_scan [2];
    bit         e_pclk [2], e_hs [2], e_vs [2], e_de [2], e_fs [2];
    logic [7:0] e_r [2], e_g [2], e_b [2];
    int         e_addr [2];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int last_fs = -1;
    bit fs_track = 1'b0;

    function automatic int active_before(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            if ((i % HT) < HA && (i / HT) < VA) c++;
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_n[k] = 0; m_scan[k] = 1'b0;
            e_pclk[k] = 1'b0; e_hs[k] = 1'b1; e_vs[k] = 1'b1; e_de[k] = 1'b0; e_fs[k] = 1'b0;
            e_r[k] = '0; e_g[k] = '0; e_b[k] = '0; e_addr[k] = -1;
        end
    endtask

    task automatic model_step(input int k, input int pd);
        bit         tk;
        int         x, y;
        logic [7:0] p;
        tk = (m_t[k] % pd) == pd - 1;
        m_t[k]++;
        e_pclk[k] = (m_t[k] % pd) >= pd / 2;
        e_fs[k] = 1'b0;
        if (tk) begin
            if (m_scan[k] && !en && m_n[k] == TOT - 1) begin
                m_scan[k] = 1'b0; m_n[k] = 0;
                e_de[k] = 1'b0; e_hs[k] = 1'b1; e_vs[k] = 1'b1;
                e_r[k] = '0; e_g[k] = '0; e_b[k] = '0; e_addr[k] = -1;
            end else if (m_scan[k] || en) begin
                x = m_n[k] % HT;
                y = m_n[k] / HT;
                e_de[k] = (x < HA) && (y < VA);
                e_hs[k] = !(x >= HA + HFP && x < HA + HFP + HS);
                e_vs[k] = !(y >= VA + VFP && y < VA + VFP + VS);
                e_addr[k] = e_de[k] ? y * HA + x : -1;
                if (e_de[k]) begin
                    p = mem[y * HA + x];
                    e_r[k] = {p[7:5], p[7:5], p[7:6]};
                    e_g[k] = {p[4:2], p[4:2], p[4:3]};
                    e_b[k] = {p[1:0], p[1:0], p[1:0], p[1:0]};
                end else begin
                    e_r[k] = '0; e_g[k] = '0; e_b[k] = '0;
                end
                e_fs[k] = (m_n[k] == 0);
                m_n[k] = (m_n[k] + 1) % TOT;
                m_scan[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0, 2);
            model_step(1, 4);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_dut(input int k, input logic [31:0] rad, input logic [23:0] rgb,
                               input logic [5:0] ctl);
        string s;
        int    erad;
        s = (k == 0) ? "A" : "B";
        erad = m_scan[k] ? active_before(m_n[k]) % NPIX : 0;
        chk({s, ".rad"}, rad, erad);
        chk({s, ".rgb"}, 32'(rgb), {8'h0, e_r[k], e_g[k], e_b[k]});
        chk({s, ".ctl{pclk,hs,vs,de,fs,busy}"}, 32'(ctl),
            32'({e_pclk[k], e_hs[k], e_vs[k], e_de[k], e_fs[k], m_scan[k]}));
        if (e_de[k] && e_addr[k] == 5) chk({s, ".rgb_E0"}, 32'(rgb), 32'h00FF0000);
        if (e_de[k] && e_addr[k] == 6) chk({s, ".rgb_03"}, 32'(rgb), 32'h000000FF);
        if (!e_de[k]) chk({s, ".rgb_blank"}, 32'(rgb), 32'h0);
    endtask

    task automatic compare_all();
        compare_dut(0, rad_a, {r_a, g_a, b_a}, {pclk_a, hs_a, vs_a, de_a, fs_a, busy_a});
        compare_dut(1, rad_b, {r_b, g_b, b_b}, {pclk_b, hs_b, vs_b, de_b, fs_b, busy_b});
    endtask

    task automatic check_idle_const(input string tag);
        chk({tag, ".A_ctl"}, 32'({hs_a, vs_a, de_a, fs_a, busy_a}), 32'b11000);
        chk({tag, ".B_ctl"}, 32'({hs_b, vs_b, de_b, fs_b, busy_b}), 32'b11000);
        chk({tag, ".A_rad"}, rad_a, 32'h0);
        chk({tag, ".B_rad"}, rad_b, 32'h0);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            compare_all();
            if (fs_track && fs_a) begin
                if (last_fs >= 0) chk("A.fs_period", cyc - last_fs, 84);
                last_fs = cyc;
            end
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hE0;
        mem[6] = 8'h03;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        compare_all();
        check_idle_const("reset");
        chk("reset.pclk", 32'({pclk_a, pclk_b}), 32'h0);

        rst_n = 1'b1;
        run_cycles($urandom_range(1, 7));

        // continuous scan
        en = 1'b1;
        fs_track = 1'b1;
        last_fs = -1;
        run_cycles(430);
        fs_track = 1'b0;

        // drop en mid-frame: frame completes then idle
        run_cycles($urandom_range(60, 110));
        en = 1'b0;
        run_cycles(400);
        check_idle_const("stop_done");

        // re-raise en during STOP
        en = 1'b1;
        run_cycles($urandom_range(100, 200));
        en = 1'b0;
        run_cycles($urandom_range(5, 40));
        en = 1'b1;
        run_cycles(300);

        // random en toggling
        repeat (25) begin
            en = 1'($urandom_range(0, 1));
            run_cycles($urandom_range(1, 80));
        end

        // async reset mid-line
        en = 1'b1;
        run_cycles($urandom_range(20, 200));
        #2 rst_n = 1'b0;
        #1 compare_all();
        check_idle_const("async_rst");
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(300);

        en = 1'b0;
        run_cycles(400);
        check_idle_const("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
